// File: rtl/ws2812_rx_if.sv
// Decoded-pixel bus between the WS2812 receiver and its consumer.
interface ws2812_rx_if;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        valid;
  logic        frame_done;
  logic [8:0]  pix_count;
  logic        error;
  logic        overflow;

  modport master (
    output rgb_data, led_num, valid, frame_done, pix_count, error, overflow
  );

  modport slave (
    input rgb_data, led_num, valid, frame_done, pix_count, error, overflow
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 serial line receiver: measures high-pulse widths on the
// synchronized line, shifts bits MSB-first into 24-bit pixels and frames
// them with the latch (reset) low gap.
//
//   state | meaning
//   SYNC  | after reset: waiting for a full latch gap before decoding
//   LOW   | line low between pulses; counter measures low time
//   HIGH  | line high; counter measures pulse width
//   ERR   | after a stuck-high pulse: waiting for a full latch gap
module ws2812_rx #(
  parameter int unsigned NUM_LEDS   = 64,
  parameter int unsigned T_MIN_HIGH = 10,
  parameter int unsigned T_THRESH   = 58,
  parameter int unsigned T_MAX_HIGH = 110,
  parameter int unsigned T_RESET    = 4800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  ws2812_rx_if.master   px
);

  localparam logic [15:0] T_MIN_C   = 16'(T_MIN_HIGH);
  localparam logic [15:0] T_THRESH_C = 16'(T_THRESH);
  localparam logic [15:0] T_MAX_C   = 16'(T_MAX_HIGH);
  localparam logic [15:0] T_RESET_C = 16'(T_RESET);
  localparam logic [8:0]  NUM_C     = 9'(NUM_LEDS);
  localparam logic [8:0]  IDX_SAT   = 9'd256;

  typedef enum logic [1:0] {SYNC, LOW, HIGH, ERR} state_t;

  state_t      state, state_n;
  logic        din_m, din_s;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [8:0]  pix_idx, pix_idx_n;
  logic [23:0] shreg, shreg_n, shifted;
  logic [23:0] rgb_q, rgb_n;
  logic [7:0]  led_q, led_n;
  logic [8:0]  pc_q, pc_n;
  logic        valid_q, valid_n;
  logic        fd_q, fd_n;
  logic        err_q, err_n;
  logic        ovf_q, ovf_n;

  // Two-flop synchronizer for the asynchronous data line.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_n;
  end

  // Datapath and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      pix_idx <= '0;
      shreg   <= '0;
      rgb_q   <= '0;
      led_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      pix_idx <= pix_idx_n;
      shreg   <= shreg_n;
      rgb_q   <= rgb_n;
      led_q   <= led_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      fd_q    <= fd_n;
      err_q   <= err_n;
      ovf_q   <= ovf_n;
    end
  end

  // Next-state, pulse classification, pixel assembly and gap handling.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    pix_idx_n = pix_idx;
    shreg_n   = shreg;
    rgb_n     = rgb_q;
    led_n     = led_q;
    pc_n      = pc_q;
    valid_n   = 1'b0;
    fd_n      = 1'b0;
    err_n     = 1'b0;
    ovf_n     = 1'b0;

    cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    shifted = {shreg[22:0], (cnt >= T_THRESH_C)};

    case (state)
      SYNC, ERR: begin
        if (din_s) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc >= T_RESET_C) begin
            state_n   = LOW;
            bit_cnt_n = '0;
            pix_idx_n = '0;
          end
        end
      end

      LOW: begin
        // The gap is closed before a coincident rising edge is taken,
        // so that edge becomes bit 0 of the next frame.
        if (cnt_inc == T_RESET_C) begin
          if ((bit_cnt != 5'd0) || (pix_idx != 9'd0)) begin
            fd_n = 1'b1;
            pc_n = (pix_idx > NUM_C) ? NUM_C : pix_idx;
          end
          if (bit_cnt != 5'd0) err_n = 1'b1;
          bit_cnt_n = '0;
          pix_idx_n = '0;
        end
        if (din_s) begin
          state_n = HIGH;
          cnt_n   = 16'd1;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      HIGH: begin
        if (din_s) begin
          if (cnt_inc > T_MAX_C) begin
            err_n     = 1'b1;
            bit_cnt_n = '0;
            cnt_n     = '0;
            state_n   = ERR;
          end else begin
            cnt_n = cnt_inc;
          end
        end else begin
          state_n = LOW;
          cnt_n   = 16'd1;
          if (cnt < T_MIN_C) begin
            err_n = 1'b1;
          end else begin
            shreg_n = shifted;
            if (bit_cnt == 5'd23) begin
              bit_cnt_n = '0;
              if (pix_idx < NUM_C) begin
                rgb_n   = shifted;
                led_n   = pix_idx[7:0];
                valid_n = 1'b1;
              end else begin
                ovf_n = 1'b1;
              end
              if (pix_idx != IDX_SAT) pix_idx_n = pix_idx + 9'd1;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end
      end

      default: state_n = SYNC;
    endcase
  end

  assign px.rgb_data   = rgb_q;
  assign px.led_num    = led_q;
  assign px.valid      = valid_q;
  assign px.frame_done = fd_q;
  assign px.pix_count  = pc_q;
  assign px.error      = err_q;
  assign px.overflow   = ovf_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives pulse-width waveforms on din and compares the
// observed event stream against an event-level model of the line protocol.
module tb_ws2812_rx;
  localparam int NUM  = 4;
  localparam int TMIN = 10;
  localparam int TTH  = 58;
  localparam int TMAX = 110;
  localparam int TRST = 600;

  localparam int K_VALID = 0;
  localparam int K_OVF   = 1;
  localparam int K_FRAME = 2;
  localparam int K_ERR   = 3;

  logic clk = 1'b0;
  logic reset;
  logic din;

  ws2812_rx_if px ();

  ws2812_rx #(
    .NUM_LEDS(NUM), .T_MIN_HIGH(TMIN), .T_THRESH(TTH),
    .T_MAX_HIGH(TMAX), .T_RESET(TRST)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .px(px)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [23:0] data;
    int          led;
    int          pc;
    int          t;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;

  // model of the protocol state
  bit          synced;
  int          bits, pix, last_pc;
  logic [23:0] cur;

  function automatic ev_t mk(int kind, logic [23:0] data, int led, int pc, int t);
    ev_t e;
    e.kind = kind; e.data = data; e.led = led; e.pc = pc; e.t = t;
    return e;
  endfunction

  // event monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (px.valid)      obs_q.push_back(mk(K_VALID, px.rgb_data, int'(px.led_num), 0, cyc));
      if (px.overflow)   obs_q.push_back(mk(K_OVF, 24'h0, 0, 0, cyc));
      if (px.frame_done) obs_q.push_back(mk(K_FRAME, 24'h0, 0, int'(px.pix_count), cyc));
      if (px.error)      obs_q.push_back(mk(K_ERR, 24'h0, 0, 0, cyc));
    end
  end

  function automatic void model_pulse(int hi, int tf);
    if (!synced) return;
    if (hi < TMIN) begin
      exp_q.push_back(mk(K_ERR, 24'h0, 0, 0, 0));
    end else if (hi > TMAX) begin
      exp_q.push_back(mk(K_ERR, 24'h0, 0, 0, 0));
      synced = 1'b0;
      bits   = 0;
    end else begin
      cur  = (cur << 1) | 24'(hi >= TTH);
      bits = bits + 1;
      if (bits == 24) begin
        bits = 0;
        if (pix < NUM) exp_q.push_back(mk(K_VALID, cur, pix, 0, tf + 3));
        else           exp_q.push_back(mk(K_OVF, 24'h0, 0, 0, 0));
        if (pix < 256) pix = pix + 1;
      end
    end
  endfunction

  function automatic void model_gap();
    if (synced) begin
      if (bits != 0 || pix != 0) begin
        last_pc = (pix < NUM) ? pix : NUM;
        exp_q.push_back(mk(K_FRAME, 24'h0, 0, last_pc, 0));
      end
      if (bits != 0) exp_q.push_back(mk(K_ERR, 24'h0, 0, 0, 0));
    end
    synced = 1'b1;
    bits   = 0;
    pix    = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    int tf;
    hold(1'b1, hi);
    tf = cyc;
    hold(1'b0, lo);
    model_pulse(hi, tf);
  endtask

  task automatic send_bits(input logic [23:0] p, input int msb, input int lsb, input bit rnd);
    for (int i = msb; i >= lsb; i--) begin
      logic b;
      int hi, lo;
      b = p[i];
      if (rnd) begin
        hi = b ? int'($urandom_range(TMAX, TTH)) : int'($urandom_range(TTH - 1, TMIN));
        lo = int'($urandom_range(30, 1));
      end else begin
        hi = b ? 77 : 38;
        lo = b ? 43 : 82;
      end
      pulse(hi, lo);
    end
  endtask

  task automatic gap();
    hold(1'b0, TRST + 50);
    model_gap();
  endtask

  task automatic check_events(input string tag);
    ev_t e, o;
    repeat (4) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_present"}, 32'(obs_q.size() > 0), 32'd1);
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        chk({tag, "_kind"}, o.kind, e.kind);
        if (e.kind == K_VALID) begin
          chk({tag, "_rgb"}, 32'(o.data), 32'(e.data));
          chk({tag, "_led"}, o.led, e.led);
          chk({tag, "_latency"}, o.t, e.t);
        end
        if (e.kind == K_FRAME) chk({tag, "_pixcnt"}, o.pc, e.pc);
      end
    end
    chk({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
    chk({tag, "_pixcnt_hold"}, 32'(px.pix_count), last_pc);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    din   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_rgb0"},   32'(px.rgb_data), 0);
    chk({tag, "_led0"},   32'(px.led_num), 0);
    chk({tag, "_pc0"},    32'(px.pix_count), 0);
    chk({tag, "_valid0"}, 32'(px.valid), 0);
    chk({tag, "_fd0"},    32'(px.frame_done), 0);
    chk({tag, "_err0"},   32'(px.error), 0);
    chk({tag, "_ovf0"},   32'(px.overflow), 0);
    reset   = 1'b0;
    synced  = 1'b0;
    bits    = 0;
    pix     = 0;
    cur     = '0;
    last_pc = 0;
    obs_q.delete();
    @(negedge clk);
  endtask

  initial begin
    din   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    do_reset("rst");

    // pixel with no preceding gap is ignored; after a gap it decodes
    send_bits(24'h5A_5A_5A, 23, 0, 1'b1);
    gap();
    check_events("nosync");
    send_bits(24'hC3_81_7E, 23, 0, 1'b0);
    gap();
    check_events("sync_pix");

    // nominal pixel
    send_bits(24'hA5_0F_3C, 23, 0, 1'b0);
    gap();
    check_events("basic");

    // idle line: no second frame_done
    gap();
    check_events("idle");

    // overflow beyond NUM pixels
    for (int n = 0; n < NUM + 2; n++) send_bits(24'($urandom), 23, 0, 1'b1);
    gap();
    check_events("ovf");

    // partial pixel at the gap
    send_bits(24'($urandom), 23, 12, 1'b1);
    gap();
    send_bits(24'($urandom), 23, 0, 1'b1);
    gap();
    check_events("partial");

    // glitch between bits
    begin
      logic [23:0] p;
      p = 24'($urandom);
      send_bits(p, 23, 14, 1'b1);
      pulse(5, 20);
      send_bits(p, 13, 0, 1'b1);
      gap();
    end
    check_events("glitch");

    // width boundaries: 10/57 -> 0, 58/110 -> 1, 9 -> glitch
    for (int i = 0; i < 24; i++) begin
      int w;
      case (i % 4)
        0: w = TMIN;
        1: w = TTH - 1;
        2: w = TTH;
        default: w = TMAX;
      endcase
      pulse(w, 1 + i);
      if (i == 5) pulse(TMIN - 1, 7);
    end
    gap();
    check_events("bound");

    // stuck high mid-pixel, ignored pixel, resync
    send_bits(24'($urandom), 23, 16, 1'b1);
    pulse(200, 30);
    send_bits(24'($urandom), 23, 0, 1'b1);
    gap();
    send_bits(24'($urandom), 23, 0, 1'b1);
    gap();
    check_events("stuck");

    // just past the stuck-high limit
    pulse(TMAX + 1, 20);
    gap();
    send_bits(24'($urandom), 23, 0, 1'b1);
    gap();
    check_events("stuck_edge");

    // reset mid-frame
    send_bits(24'($urandom | 1), 23, 0, 1'b1);
    send_bits(24'($urandom), 23, 14, 1'b1);
    check_events("pre_rst");
    do_reset("midrst");
    send_bits(24'($urandom), 23, 0, 1'b1);
    gap();
    send_bits(24'($urandom), 23, 0, 1'b1);
    gap();
    check_events("post_rst");

    // random frames
    for (int f = 0; f < 2; f++) begin
      int np;
      np = int'($urandom_range(2, 1));
      for (int n = 0; n < np; n++) begin
        logic [23:0] p;
        p = 24'($urandom);
        send_bits(p, 23, 8, 1'b1);
        if ($urandom_range(1, 0) == 1) pulse(int'($urandom_range(TMIN - 1, 1)), 15);
        send_bits(p, 7, 0, 1'b1);
      end
      gap();
      check_events("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter NUM_LEDS, default 64: pixels accepted per frame; further pixels are overflow.
REQ-002 Parameter T_MIN_HIGH, default 10: high pulses shorter than this many clk cycles are glitches.
REQ-003 Parameter T_THRESH, default 58: a high pulse of at least this many cycles decodes as 1, otherwise 0 (0.6 us at 96 MHz).
REQ-004 Parameter T_MAX_HIGH, default 110: a high pulse longer than this is a stuck-high error.
REQ-005 Parameter T_RESET, default 4800: a low time of at least this many cycles is a latch/reset gap (50 us at 96 MHz).
REQ-006 clk  input  1  single clock for all logic (96 MHz nominal).
REQ-007 reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-008 din  input  1  WS2812 serial data line, asynchronous to clk.
REQ-009 rgb_data  output  24  last decoded pixel; bit 23 = first bit received on the wire.
REQ-010 led_num  output  8  index of the pixel in rgb_data, 0 = first pixel after a gap.
REQ-011 valid  output  1  one-cycle pulse: rgb_data/led_num hold a new pixel.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each latch gap that follows received bits.
REQ-013 pix_count  output  9  pixels received in the frame just ended; valid while frame_done=1 and held until the next frame_done.
REQ-014 error  output  1  one-cycle pulse on glitch, stuck-high, or partial-pixel condition.
REQ-015 overflow  output  1  one-cycle pulse per pixel received beyond NUM_LEDS.

Function
REQ-016 din shall pass through a two-flop synchronizer; all decoding uses the synchronized signal din_s.
REQ-017 FSM states shall be SYNC, LOW, HIGH and ERR; one 16-bit cycle counter saturates at 16'hFFFF.
REQ-018 In SYNC, the counter counts consecutive din_s=0 cycles, and din_s=1 clears it; reaching T_RESET moves the FSM to LOW with bit count 0 and led_num 0, without asserting frame_done.
REQ-019 In LOW, a din_s rising edge moves the FSM to HIGH with the counter at 1; otherwise the counter increments.
REQ-020 In HIGH, the counter increments while din_s=1; a din_s falling edge classifies the pulse from the count and returns the FSM to LOW with the counter at 1.
REQ-021 Classification: a count below T_MIN_HIGH asserts error and discards the pulse (bit count unchanged); a count of at least T_THRESH shifts in 1; any other count shifts in 0.
REQ-022 When the count in HIGH exceeds T_MAX_HIGH, the block shall assert error, clear the bit count and enter ERR.
REQ-023 ERR behaves as SYNC, requiring T_RESET low cycles before returning to LOW.
REQ-024 Bits shift MSB-first into a 24-bit register; bit count runs 0..23.
REQ-025 On the 24th bit with internal pixel index < NUM_LEDS, the block shall update rgb_data and led_num and pulse valid.
REQ-026 valid shall pulse on the clk cycle after din_s falls; latency from the din pin fall to valid high is 3 clk.
REQ-027 On the 24th bit with index >= NUM_LEDS, the block shall pulse overflow, leave rgb_data/led_num and valid unchanged, and saturate the index at 256.
REQ-028 In LOW, when the counter reaches exactly T_RESET, the block shall pulse frame_done if any bit or pixel was received since the last gap.
REQ-029 At that same T_RESET point, pix_count takes the number of pixels accepted, clamped to NUM_LEDS; the pixel index and bit count clear.
REQ-030 At that same T_RESET point, if the bit count is nonzero, error shall pulse together with frame_done and the partial bits are discarded.
REQ-031 A gap longer than T_RESET shall produce exactly one frame_done; an idle line produces none.
REQ-032 A rising edge arriving on the same cycle the counter reaches T_RESET: the gap completes first, and the new pulse then starts bit 0 of a new frame.
REQ-033 Low time between bits has no minimum or maximum other than T_RESET.

Reset
REQ-034 While reset=1, the FSM shall go to SYNC, with counter, bit count, pixel index, shift register, rgb_data, led_num and pix_count at 0.
REQ-035 While reset=1, valid, frame_done, error and overflow shall be 0, and the synchronizer flops shall be 0.
REQ-036 A reset mid-frame shall discard the partial pixel, and a new T_RESET low gap is required before decoding.

Verification
REQ-037 After reset, drive 4800 low cycles, then pixel 24'hA5_0F_3C (1 = 77 high/43 low, 0 = 38 high/82 low), then 4800 low -> one valid with rgb_data=24'hA5_0F_3C and led_num=0, then frame_done with pix_count=1 and no error.
REQ-038 After sync, send 64 pixels of 24'h10_00_00 followed by 2 of 24'h00_10_00, then a gap -> 64 valid pulses with led_num 0..63, 2 overflow pulses, and frame_done with pix_count=64.
REQ-039 After sync, send 12 bits then a 4800-cycle gap -> frame_done and error in the same cycle, no valid; the next full pixel decodes with led_num=0.
REQ-040 After sync, insert a 5-cycle high glitch between bits of a pixel -> one error pulse, and the pixel still decodes correctly.
REQ-041 Hold din high for 200 cycles mid-pixel -> error when the count exceeds 110, no valid until 4800 low cycles have passed, then normal decoding.
REQ-042 Without the initial gap after reset, send a pixel -> no valid; then send a gap followed by a pixel -> valid with led_num=0.
